seg_scan_driver: RTL and testbench

Time-multiplexed driver for an N-digit common-anode 7-segment display. It holds an N-nibble value and scans one digit at a time, using a prescaled refresh tick. Each nibble is encoded to a segment code with optional hex glyphs, per-digit decimal points and leading-zero blanking. New values are double-buffered and committed only at frame boundaries, so a display never shows a partial update. It replaces per-digit static nibble encoders between the counter logic and the board display pins.

---
 rtl/seg_scan_driver.sv | 128 ++++++++++++
 tb/tb_seg_scan_driver.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with frame-aligned
// double buffering, optional hex glyphs, per-digit decimal points and leading-zero blanking.
module seg_scan_driver #(
    parameter int NUM_DIGITS       = 4,
    parameter int CLK_DIV          = 50000,
    parameter int HEX_MODE         = 1,
    parameter int DIGIT_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lead,
    output logic [7:0]              disp_code_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_IDLE = {NUM_DIGITS{DIGIT_ACTIVE_LOW != 0}};

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] pend_val, disp_val;
    logic [NUM_DIGITS-1:0]   pend_dp, disp_dp;
    logic                    pend_valid;

    logic                    tick, wrap, commit;
    logic [3:0]              cur_nib;
    logic                    cur_dp, higher_nz, blank;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [7:0]              seg_next;
    logic [NUM_DIGITS-1:0]   sel_next;

    // Active-low g..a patterns; hex glyphs collapse to blank when HEX_MODE is off.
    function automatic logic [6:0] encode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = (HEX_MODE != 0) ? 7'h08 : 7'h7F;
            4'hB: s = (HEX_MODE != 0) ? 7'h03 : 7'h7F;
            4'hC: s = (HEX_MODE != 0) ? 7'h46 : 7'h7F;
            4'hD: s = (HEX_MODE != 0) ? 7'h21 : 7'h7F;
            4'hE: s = (HEX_MODE != 0) ? 7'h06 : 7'h7F;
            default: s = (HEX_MODE != 0) ? 7'h0E : 7'h7F;
        endcase
        return s;
    endfunction

    assign tick   = enable && (cnt == CNT_LAST);
    assign wrap   = tick && (idx == IDX_LAST);
    // While dark there is no frame to tear, so pending data goes straight through.
    assign commit = pend_valid && (wrap || !enable);

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        higher_nz = 1'b0;
        onehot    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == idx) begin
                cur_nib   = disp_val[4*i +: 4];
                cur_dp    = disp_dp[i];
                onehot[i] = 1'b1;
            end
            if (IW'(i) >= idx && disp_val[4*i +: 4] != 4'h0)
                higher_nz = 1'b1;
        end
        blank    = blank_lead && (idx != '0) && !higher_nz;
        seg_next = {~cur_dp, blank ? 7'h7F : encode(cur_nib)};
        sel_next = (DIGIT_ACTIVE_LOW != 0) ? ~onehot : onehot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            idx           <= '0;
            pend_val      <= '0;
            pend_dp       <= '0;
            pend_valid    <= 1'b0;
            disp_val      <= '0;
            disp_dp       <= '0;
            frame_done    <= 1'b0;
            disp_code_out <= 8'hFF;
            digit_sel     <= SEL_IDLE;
        end else begin
            if (!enable) begin
                cnt <= '0;
                idx <= '0;
            end else if (tick) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (commit) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
            end
            // A load coinciding with a commit refills pending, so valid stays set.
            if (load) begin
                pend_val <= value_in;
                pend_dp  <= dp_in;
            end
            pend_valid <= load || (pend_valid && !commit);

            frame_done    <= wrap;
            disp_code_out <= enable ? seg_next : 8'hFF;
            digit_sel     <= enable ? sel_next : SEL_IDLE;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (4 digits, CLK_DIV=4); a hex and a non-hex
// instance share stimulus, expected per-digit outputs are queued then checked per frame.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] value_in = '0;
    logic        load = 1'b0;
    logic [3:0]  dp_in = '0;
    logic        blank_lead = 1'b0;
    logic [7:0]  code, code_nh;
    logic [3:0]  sel, sel_nh;
    logic        fd, fd_nh;

    int total = 0;
    int bad   = 0;
    // entry = {digit_sel, code (hex dut), code (non-hex dut)}
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    seg_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .HEX_MODE(1), .DIGIT_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .value_in(value_in), .load(load),
        .dp_in(dp_in), .blank_lead(blank_lead), .disp_code_out(code), .digit_sel(sel),
        .frame_done(fd));

    seg_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .HEX_MODE(0), .DIGIT_ACTIVE_LOW(1)) dut_nh (
        .clk(clk), .rst_n(rst_n), .enable(enable), .value_in(value_in), .load(load),
        .dp_in(dp_in), .blank_lead(blank_lead), .disp_code_out(code_nh), .digit_sel(sel_nh),
        .frame_done(fd_nh));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // c / cn hold digit3..digit0 codes, one byte each.
    task automatic push_frame(input logic [31:0] c, input logic [31:0] cn);
        logic [3:0] s;
        for (int k = 0; k < 4; k++) begin
            s = ~(4'b0001 << k);
            exp_q.push_back({s, c[8*k +: 8], cn[8*k +: 8]});
        end
    endtask

    // Waits for a frame wrap, then checks the full following frame slot by slot.
    task automatic check_frame(input string tag);
        int n;
        logic [19:0] e;
        n = 0;
        while (fd !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ":frame_wait"}, 32'(fd), 32'd1);
        for (int d = 0; d < 4; d++) begin
            if (exp_q.size() == 0) begin
                chk({tag, ":queue_empty"}, 32'd0, 32'd1);
                return;
            end
            e = exp_q.pop_front();
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                chk($sformatf("%s:d%0d:sel", tag, d), 32'(sel), 32'(e[19:16]));
                chk($sformatf("%s:d%0d:code", tag, d), 32'(code), 32'(e[15:8]));
                chk($sformatf("%s:d%0d:sel_nh", tag, d), 32'(sel_nh), 32'(e[19:16]));
                chk($sformatf("%s:d%0d:code_nh", tag, d), 32'(code_nh), 32'(e[7:0]));
                chk($sformatf("%s:d%0d:frame_done", tag, d), 32'(fd),
                    (d == 3 && c == 3) ? 32'd1 : 32'd0);
            end
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] dp);
        value_in = v;
        dp_in    = dp;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    initial begin
        // reset held, then released with scanning disabled
        tick_n(2);
        chk("rst:code", 32'(code), 32'hFF);
        chk("rst:sel", 32'(sel), 32'hF);
        chk("rst:fd", 32'(fd), 32'd0);
        rst_n = 1'b1;
        tick_n(3);
        chk("dis:code", 32'(code), 32'hFF);
        chk("dis:sel", 32'(sel), 32'hF);
        chk("dis:fd", 32'(fd), 32'd0);

        // basic scan of 1234
        push_frame(32'hF9_A4_B0_99, 32'hF9_A4_B0_99);
        pulse_load(16'h1234, 4'b0000);
        enable = 1'b1;
        check_frame("basic");

        // hex glyphs with leading-zero blanking
        push_frame(32'hFF_FF_88_8E, 32'hFF_FF_FF_FF);
        blank_lead = 1'b1;
        pulse_load(16'h00AF, 4'b0000);
        check_frame("hex");

        // all-zero value: digit0 kept, blanked digit2 keeps its dp
        push_frame(32'hFF_7F_FF_C0, 32'hFF_7F_FF_C0);
        pulse_load(16'h0000, 4'b0100);
        check_frame("blank_dp");

        // mid-frame load must not disturb the frame in progress
        tick_n(5);
        pulse_load(16'h5678, 4'b0000);
        tick_n(3);
        chk("hold_old:sel", 32'(sel), 32'hB);
        chk("hold_old:code", 32'(code), 32'h7F);
        push_frame(32'h92_82_F8_80, 32'h92_82_F8_80);
        check_frame("tearfree");

        // load coinciding with commit: 4321 shows for one frame, then 9999
        tick_n(2);
        pulse_load(16'h4321, 4'b0000);
        tick_n(12);
        push_frame(32'h99_B0_A4_F9, 32'h99_B0_A4_F9);
        push_frame(32'h90_90_90_90, 32'h90_90_90_90);
        pulse_load(16'h9999, 4'b0000);
        check_frame("same_cycle_old");
        check_frame("same_cycle_new");

        // asynchronous reset during digit2 with pending data outstanding
        blank_lead = 1'b0;
        pulse_load(16'h1111, 4'b1111);
        tick_n(8);
        chk("pre_rst:sel", 32'(sel), 32'hB);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst:code", 32'(code), 32'hFF);
        chk("async_rst:sel", 32'(sel), 32'hF);
        chk("async_rst:fd", 32'(fd), 32'd0);
        tick_n(3);
        rst_n = 1'b1;
        push_frame(32'hC0_C0_C0_C0, 32'hC0_C0_C0_C0);
        check_frame("after_rst");

        // disabling goes dark; a load while dark commits, scan restarts at digit0
        enable = 1'b0;
        tick_n(2);
        chk("dark:code", 32'(code), 32'hFF);
        chk("dark:sel", 32'(sel), 32'hF);
        pulse_load(16'h0008, 4'b0000);
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        chk("restart:sel", 32'(sel), 32'hE);
        chk("restart:code", 32'(code), 32'h80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
